// File: rtl/oht_bit_packer_pkg.sv
// Shared types and helpers for the OHT bit packer.
// Holds the packer FSM state encoding and the counter-width helper.
package oht_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } packer_state_e;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/oht_bit_packer_if.sv
// Stream bundle for the OHT bit packer: masked input beats, packed output words, flush control.
// The packer connects through the slave modport; the producer/consumer side uses master.
interface oht_bit_packer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int BUF_WIDTH = 96
);
    localparam int OCW = oht_pkg::cnt_width(OUT_WIDTH);
    localparam int BCW = oht_pkg::cnt_width(BUF_WIDTH);

    logic [IN_WIDTH-1:0]  in_data;
    logic [IN_WIDTH-1:0]  in_mask;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [OUT_WIDTH-1:0] out_data;
    logic [OCW-1:0]       out_count;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic                 flush_done;
    logic [BCW-1:0]       buf_count;

    modport slave (
        input  in_data, in_mask, in_valid, flush, out_ready,
        output in_ready, out_data, out_count, out_last, out_valid, flush_done, buf_count
    );

    modport master (
        output in_data, in_mask, in_valid, flush, out_ready,
        input  in_ready, out_data, out_count, out_last, out_valid, flush_done, buf_count
    );

endinterface

// File: rtl/oht_bit_packer_mask.sv
// Combinational mask compaction: kept data bits are packed toward bit 0 in index order,
// and num_good_o reports how many were kept.
module oht_mask_compact
    import oht_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int NGW      = cnt_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] data_i,
    input  logic [IN_WIDTH-1:0] mask_i,
    output logic [IN_WIDTH-1:0] compacted_o,
    output logic [NGW-1:0]      num_good_o
);

    // NOTE: every variable written in always_comb is given a default first so no path
    // leaves it unassigned; that is what keeps synthesis from inferring a latch.
    always_comb begin
        compacted_o = '0;
        num_good_o  = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (mask_i[i]) begin
                compacted_o = compacted_o | (IN_WIDTH'(data_i[i]) << num_good_o);
                num_good_o  = num_good_o + NGW'(1);
            end
        end
    end

endmodule

// File: rtl/oht_bit_packer.sv
// OHT bit packer: compacts masked input beats into a bit buffer and emits OUT_WIDTH words,
// with flush of a zero-padded partial word. Optional counters under OHT_PACKER_STATS_EN.
module oht_bit_packer
    import oht_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int BUF_WIDTH = 96
) (
    input  logic            clk,
    input  logic            rst,
    oht_bit_packer_if.slave bus_if
`ifdef OHT_PACKER_STATS_EN
    ,
    output logic [31:0]     stat_bits_in,
    output logic [31:0]     stat_words_out
`endif
);

    localparam int NGW = cnt_width(IN_WIDTH);
    localparam int OCW = cnt_width(OUT_WIDTH);
    localparam int BCW = cnt_width(BUF_WIDTH);
    localparam logic [BCW-1:0] OUT_W_C  = BCW'(OUT_WIDTH);
    localparam logic [BCW-1:0] IN_LIMIT = BCW'(BUF_WIDTH - IN_WIDTH);

    if (BUF_WIDTH < IN_WIDTH + OUT_WIDTH) begin : g_bad_cfg
        $error("oht_bit_packer: BUF_WIDTH must be at least IN_WIDTH + OUT_WIDTH");
    end

    packer_state_e        state_q, state_d;
    logic [BUF_WIDTH-1:0] buf_q, buf_d;
    logic [BCW-1:0]       cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [OCW-1:0]       out_count_q, out_count_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;
    logic                 flush_done_q, flush_done_d;

    logic [IN_WIDTH-1:0]  compacted;
    logic [NGW-1:0]       num_good;
    logic                 in_ready_w;
    logic                 fire_in;
    logic                 slot_free;
    logic                 load_full;
    logic                 load_part;

    oht_mask_compact #(
        .IN_WIDTH (IN_WIDTH),
        .NGW      (NGW)
    ) u_compact (
        .data_i      (bus_if.in_data),
        .mask_i      (bus_if.in_mask),
        .compacted_o (compacted),
        .num_good_o  (num_good)
    );

    // Decoded from registered state only, so out_ready never reaches in_ready.
    assign in_ready_w = (state_q == RUN) && (cnt_q <= IN_LIMIT);
    assign fire_in    = bus_if.in_valid && in_ready_w;
    assign slot_free  = !out_valid_q || bus_if.out_ready;
    assign load_full  = slot_free && (cnt_q >= OUT_W_C);
    assign load_part  = (state_q == DRAIN) && slot_free && (cnt_q < OUT_W_C) && (cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus_if.flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (slot_free && (cnt_q < OUT_W_C)) state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !bus_if.out_ready;

        if (load_full) begin
            out_data_d  = buf_q[OUT_WIDTH-1:0];
            out_count_d = OCW'(OUT_WIDTH);
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            buf_d       = buf_q >> OUT_WIDTH;
            cnt_d       = cnt_q - OUT_W_C;
        end else if (load_part) begin
            // Bits above cnt_q are always zero, so the low slice is already zero-padded.
            out_data_d  = buf_q[OUT_WIDTH-1:0];
            out_count_d = OCW'(cnt_q);
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            buf_d       = '0;
            cnt_d       = '0;
        end

        // Append after any pop so new bits land directly above the survivors.
        if (fire_in) begin
            buf_d = buf_d | (BUF_WIDTH'(compacted) << cnt_d);
            cnt_d = cnt_d + BCW'(num_good);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register
    // samples its pre-edge inputs; blocking here would create ordering-dependent races.
    // NOTE: the bit buffer is a flat register (not a RAM), so resetting it is cheap and
    // guarantees stale bits never leak into a later partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus_if.in_ready   = in_ready_w;
    assign bus_if.out_data   = out_data_q;
    assign bus_if.out_count  = out_count_q;
    assign bus_if.out_last   = out_last_q;
    assign bus_if.out_valid  = out_valid_q;
    assign bus_if.flush_done = flush_done_q;
    assign bus_if.buf_count  = cnt_q;

`ifdef OHT_PACKER_STATS_EN
    logic [31:0] stat_bits_q;
    logic [31:0] stat_words_q;
    logic [32:0] bits_sum;

    assign bits_sum = {1'b0, stat_bits_q} + 33'(num_good);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bits_q  <= '0;
            stat_words_q <= '0;
        end else begin
            if (fire_in) stat_bits_q <= bits_sum[32] ? '1 : bits_sum[31:0];
            if (out_valid_q && bus_if.out_ready && (stat_words_q != '1))
                stat_words_q <= stat_words_q + 32'd1;
        end
    end

    assign stat_bits_in   = stat_bits_q;
    assign stat_words_out = stat_words_q;
`endif

endmodule
